seq_detector: RTL and testbench
===============================

SEQ_DETECTOR -- requirements
Module: seq_detector

Interface
REQ-001 SHALL have parameter PAT_LEN, default 4, giving the pattern length in bits (legal range 2..16).
REQ-002 SHALL have parameter CNT_W, default 8, giving the match counter width in bits.
REQ-003 SHALL have port clk, input, 1 bit, single clock; all state updates occur on its rising edge.
REQ-004 SHALL have port reset, input, 1 bit, asynchronous active-low reset.
REQ-005 SHALL have port pattern_load, input, 1 bit, which captures pattern and re-arms the detector.
REQ-006 SHALL have port pattern, input, PAT_LEN bits, the target sequence; bit PAT_LEN-1 is the first bit expected.
REQ-007 SHALL have port in_valid, input, 1 bit, which qualifies in_bit.
REQ-008 SHALL have port in_bit, input, 1 bit, serial data.
REQ-009 SHALL have port overlap, input, 1 bit; 1 = overlapping matches, 0 = non-overlapping.
REQ-010 SHALL have port cnt_clr, input, 1 bit, a synchronous clear of match_cnt.
REQ-011 SHALL have port match, output, 1 bit, a one-cycle pulse per detected match.
REQ-012 SHALL have port match_cnt, output, CNT_W bits, the number of matches since the last clear or load.
REQ-013 SHALL have port armed, output, 1 bit, high when a pattern is loaded and detection is active.

Function
REQ-014 SHALL implement FSM states IDLE (no pattern), FILL (fewer than PAT_LEN valid bits held) and ARMED_FULL (history full).
REQ-015 SHALL transition IDLE->FILL on pattern_load, FILL->ARMED_FULL when fill count reaches PAT_LEN, and ARMED_FULL->FILL on a non-overlap match.
REQ-016 SHALL, on pattern_load, register pattern and clear the history shift register, the fill count (0) and match_cnt; this takes effect from the next edge.
REQ-017 SHALL, when in_valid=1 outside IDLE, shift in_bit into the LSB of a PAT_LEN-bit history and increment the fill count, saturating at PAT_LEN.
REQ-018 SHALL ignore the cycle when in_valid=0: no shift, no count change.
REQ-019 SHALL ignore in_valid in IDLE: no shift and no match.
REQ-020 SHALL assert match for exactly one cycle, on the edge after the accepting edge (latency 1), when the post-shift history equals the pattern and the post-shift fill equals PAT_LEN.
REQ-021 SHALL keep the fill count at PAT_LEN after a match when overlap=1, so consecutive overlapping matches are detected.
REQ-022 SHALL, when overlap=0, reset the fill count to 0 on the matching edge so that no bit is shared between matches.
REQ-023 SHALL have pattern_load take priority when it coincides with in_valid: in_bit is discarded and no match is produced.
REQ-024 SHALL, when cnt_clr coincides with a match, leave match_cnt at 1 (the clear applies first, then the increment); pattern_load overrides both.
REQ-025 SHALL sample overlap on every accepting edge; a change of overlap takes effect from the next accepted bit.
REQ-026 SHALL drive armed high in FILL and ARMED_FULL and low in IDLE.

Reset
REQ-027 SHALL, while reset=0, asynchronously force state=IDLE, history=0, pattern register=0, fill=0, match=0, match_cnt=0, armed=0.
REQ-028 SHALL, on reset asserted mid-sequence, discard all partial history; after deassertion a pattern_load is required before any match.

Configuration
REQ-029 SHALL, when macro SEQ_DETECTOR_CNT_SAT_EN is defined, hold match_cnt at 2^CNT_W-1 on further matches (saturate) while match still pulses.
REQ-030 SHALL, when SEQ_DETECTOR_CNT_SAT_EN is undefined, wrap match_cnt modulo 2^CNT_W (all-ones + 1 -> 0).

Verification (PAT_LEN=4, CNT_W=8 unless stated)
REQ-031 SHALL cover basic match: load 4'b1011; valid bits 1,0,1,1 -> match=1 one cycle after the 4th bit, match_cnt=1.
REQ-032 SHALL cover overlap: load 4'b1010, overlap=1, bits 1,0,1,0,1,0 -> match after bits 4 and 6, match_cnt=2; same with overlap=0 -> match after bit 4 only, match_cnt=1.
REQ-033 SHALL cover valid gaps and IDLE: toggle in_valid 1,0,1 between pattern bits -> same result as the gap-free case; bits sent before any pattern_load -> no match, armed=0.
REQ-034 SHALL cover load collision: pattern_load asserted in the same cycle as the final matching bit -> no match, match_cnt=0, fill=0.
REQ-035 SHALL cover counter limits: CNT_W=2, six matches -> match_cnt=3 with SEQ_DETECTOR_CNT_SAT_EN defined, and 2 without it.
REQ-036 SHALL cover reset mid-stream: reset=0 after bits 1,0,1 of 4'b1011; release, reload, send 1 -> no match; then send 0,1,1 -> match.

Source files
------------

// File: rtl/seq_detector.sv
// seq_detector: serial pattern detector with a programmable PAT_LEN-bit target,
// selectable overlapping / non-overlapping matching and a match counter.
// Optional feature macro: SEQ_DETECTOR_CNT_SAT_EN -- when defined the match
// counter saturates at all-ones; when undefined it wraps modulo 2^CNT_W.
module seq_detector #(
   parameter int PAT_LEN = 4,
   parameter int CNT_W   = 8
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               pattern_load,
   input  logic [PAT_LEN-1:0] pattern,
   input  logic               in_valid,
   input  logic               in_bit,
   input  logic               overlap,
   input  logic               cnt_clr,
   output logic               match,
   output logic [CNT_W-1:0]   match_cnt,
   output logic               armed
);

   localparam int                FILL_W    = $clog2(PAT_LEN + 1);
   localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(PAT_LEN);

   typedef enum logic [1:0] {
      IDLE       = 2'd0,
      FILL       = 2'd1,
      ARMED_FULL = 2'd2
   } state_t;

   state_t             state_q, state_d;
   logic [PAT_LEN-1:0] pat_q, pat_d;
   logic [PAT_LEN-1:0] hist_q, hist_d;
   logic [PAT_LEN-1:0] hist_shift;
   logic [FILL_W-1:0]  fill_q, fill_d;
   logic [FILL_W-1:0]  fill_inc;
   logic               match_q, match_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic [CNT_W-1:0]   cnt_base;
   logic [CNT_W-1:0]   cnt_inc;
   logic               accept;
   logic               hit;

   // Accepted-bit qualification, post-shift history and match condition
   always_comb begin
      accept     = in_valid && (state_q != IDLE) && !pattern_load;
      hist_shift = (hist_q << 1) | PAT_LEN'(in_bit);
      fill_inc   = (fill_q == FILL_FULL) ? fill_q : fill_q + FILL_W'(1);
      hit        = accept && (hist_shift == pat_q) && (fill_inc == FILL_FULL);
   end

   // Counter arithmetic: a coincident clear is applied before the increment
   always_comb begin
      cnt_base = cnt_clr ? '0 : cnt_q;
`ifdef SEQ_DETECTOR_CNT_SAT_EN
      cnt_inc  = (&cnt_base) ? cnt_base : cnt_base + CNT_W'(1);
`else
      cnt_inc  = cnt_base + CNT_W'(1);
`endif
   end

   // FSM state register
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // FSM next-state logic; a load always re-arms into FILL
   always_comb begin
      state_d = state_q;
      if (pattern_load) begin
         state_d = FILL;
      end else if (accept) begin
         if (hit && !overlap) begin
            state_d = FILL;
         end else if (fill_inc == FILL_FULL) begin
            state_d = ARMED_FULL;
         end else begin
            state_d = FILL;
         end
      end
   end

   // Datapath next-state: load has priority over shifting and counting
   always_comb begin
      pat_d   = pat_q;
      hist_d  = hist_q;
      fill_d  = fill_q;
      match_d = 1'b0;
      cnt_d   = cnt_base;
      if (pattern_load) begin
         pat_d  = pattern;
         hist_d = '0;
         fill_d = '0;
         cnt_d  = '0;
      end else if (accept) begin
         hist_d = hist_shift;
         // Non-overlapping mode restarts the fill so no bit is shared
         fill_d = (hit && !overlap) ? '0 : fill_inc;
         if (hit) begin
            match_d = 1'b1;
            cnt_d   = cnt_inc;
         end
      end
   end

   // Datapath registers
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         pat_q   <= '0;
         hist_q  <= '0;
         fill_q  <= '0;
         match_q <= 1'b0;
         cnt_q   <= '0;
      end else begin
         pat_q   <= pat_d;
         hist_q  <= hist_d;
         fill_q  <= fill_d;
         match_q <= match_d;
         cnt_q   <= cnt_d;
      end
   end

   // Output logic
   always_comb begin
      armed     = (state_q != IDLE);
      match     = match_q;
      match_cnt = cnt_q;
   end

endmodule

// File: tb/tb_seq_detector.sv
// Scoreboard bench for seq_detector: stimulus pushes expected matches and
// state checks into queues, a monitor on the falling edge pops and compares.
module tb_seq_detector;

   logic       clk = 1'b0;
   logic       reset = 1'b0;
   logic       pattern_load = 1'b0;
   logic [3:0] pattern = 4'b0000;
   logic       in_valid = 1'b0;
   logic       in_bit = 1'b0;
   logic       overlap = 1'b0;
   logic       cnt_clr = 1'b0;
   logic       match;
   logic [7:0] match_cnt;
   logic       armed;
   logic       match2;
   logic [1:0] match_cnt2;
   logic       armed2;

   int n_cmp = 0;
   int n_bad = 0;
   int cyc = 0;

   typedef struct packed {
      logic [31:0] due;
      logic [7:0]  cnt;
   } exp_t;

   typedef struct packed {
      logic [7:0]  kind;
      logic [31:0] val;
   } chk_t;

   exp_t exp_q[$];
   chk_t chk_q[$];

   localparam int K_ARMED = 0;
   localparam int K_CNT   = 1;
   localparam int K_CNT2  = 2;
   localparam int K_QEMPTY = 3;

`ifdef SEQ_DETECTOR_CNT_SAT_EN
   localparam int CNT2_EXP = 3;
`else
   localparam int CNT2_EXP = 2;
`endif

   seq_detector #(.PAT_LEN(4), .CNT_W(8)) dut (
      .clk(clk), .reset(reset), .pattern_load(pattern_load), .pattern(pattern),
      .in_valid(in_valid), .in_bit(in_bit), .overlap(overlap), .cnt_clr(cnt_clr),
      .match(match), .match_cnt(match_cnt), .armed(armed)
   );

   seq_detector #(.PAT_LEN(4), .CNT_W(2)) dut2 (
      .clk(clk), .reset(reset), .pattern_load(pattern_load), .pattern(pattern),
      .in_valid(in_valid), .in_bit(in_bit), .overlap(overlap), .cnt_clr(cnt_clr),
      .match(match2), .match_cnt(match_cnt2), .armed(armed2)
   );

   always #5 clk = ~clk;

   initial begin
      forever begin
         @(posedge clk);
         cyc++;
      end
   end

   // Monitor: consumes expected matches and pending state checks
   initial begin
      exp_t e;
      chk_t c;
      int   act;
      forever begin
         @(negedge clk);
         if (match) begin
            n_cmp++;
            if (exp_q.size() == 0) begin
               n_bad++;
               $display("FAIL unexpected_match: cyc=%0d match=1 required=0 (cnt=%0d)", cyc, match_cnt);
            end else begin
               e = exp_q.pop_front();
               if (e.due != cyc || match_cnt != e.cnt) begin
                  n_bad++;
                  $display("FAIL match: cyc=%0d cnt=%0d required cyc=%0d cnt=%0d", cyc, match_cnt, e.due, e.cnt);
               end else begin
                  $display("match ok: cyc=%0d cnt=%0d", cyc, match_cnt);
               end
            end
         end else if (exp_q.size() > 0 && int'(exp_q[0].due) <= cyc) begin
            e = exp_q.pop_front();
            n_cmp++;
            n_bad++;
            $display("FAIL missing_match: cyc=%0d match=0 required=1 cnt=%0d", cyc, e.cnt);
         end
         while (chk_q.size() > 0) begin
            c = chk_q.pop_front();
            case (int'(c.kind))
               K_ARMED: act = int'(armed);
               K_CNT:   act = int'(match_cnt);
               K_CNT2:  act = int'(match_cnt2);
               default: act = exp_q.size();
            endcase
            n_cmp++;
            if (act != int'(c.val)) begin
               n_bad++;
               $display("FAIL check kind=%0d: cyc=%0d actual=%0d required=%0d", c.kind, cyc, act, c.val);
            end else begin
               $display("check ok kind=%0d: cyc=%0d value=%0d", c.kind, cyc, act);
            end
         end
      end
   end

   task automatic step(input logic ld, input logic [3:0] pat, input logic v,
                       input logic b, input logic clr, input logic em, input int ec);
      pattern_load = ld;
      pattern      = pat;
      in_valid     = v;
      in_bit       = b;
      cnt_clr      = clr;
      if (em) exp_q.push_back('{due: 32'(cyc + 1), cnt: 8'(ec)});
      @(posedge clk);
      #1;
      pattern_load = 1'b0;
      in_valid     = 1'b0;
      cnt_clr      = 1'b0;
   endtask

   task automatic load(input logic [3:0] p);
      step(1'b1, p, 1'b0, 1'b0, 1'b0, 1'b0, 0);
   endtask

   task automatic bit_in(input logic b, input logic em, input int ec);
      step(1'b0, pattern, 1'b1, b, 1'b0, em, ec);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(1'b0, pattern, 1'b0, 1'b0, 1'b0, 1'b0, 0);
   endtask

   task automatic chk(input int kind, input int val);
      chk_q.push_back('{kind: 8'(kind), val: 32'(val)});
   endtask

   initial begin
      // Reset state
      repeat (2) @(posedge clk);
      #1;
      chk(K_ARMED, 0);
      chk(K_CNT, 0);
      idle(1);
      reset = 1'b1;

      // Bits before any load are ignored (pattern register is 0000)
      bit_in(0, 0, 0); bit_in(0, 0, 0); bit_in(0, 0, 0); bit_in(0, 0, 0);
      bit_in(1, 0, 0); bit_in(0, 0, 0); bit_in(1, 0, 0); bit_in(1, 0, 0);
      chk(K_ARMED, 0);
      idle(1);

      // Basic match 1011
      load(4'b1011);
      chk(K_ARMED, 1);
      chk(K_CNT, 0);
      bit_in(1, 0, 0); bit_in(0, 0, 0); bit_in(1, 0, 0); bit_in(1, 1, 1);
      idle(1);
      chk(K_CNT, 1);
      idle(1);

      // Same pattern with valid gaps
      load(4'b1011);
      bit_in(1, 0, 0); idle(1); bit_in(0, 0, 0); idle(2);
      bit_in(1, 0, 0); idle(1); bit_in(1, 1, 1);
      idle(2);

      // Overlapping 1010
      overlap = 1'b1;
      load(4'b1010);
      bit_in(1, 0, 0); bit_in(0, 0, 0); bit_in(1, 0, 0); bit_in(0, 1, 1);
      bit_in(1, 0, 0); bit_in(0, 1, 2);
      idle(1);
      chk(K_CNT, 2);
      idle(1);

      // Non-overlapping 1010: second match needs four fresh bits
      overlap = 1'b0;
      load(4'b1010);
      bit_in(1, 0, 0); bit_in(0, 0, 0); bit_in(1, 0, 0); bit_in(0, 1, 1);
      bit_in(1, 0, 0); bit_in(0, 0, 0);
      chk(K_CNT, 1);
      bit_in(1, 0, 0); bit_in(0, 1, 2);
      idle(2);

      // Clear coinciding with a match leaves the count at 1; plain clear gives 0
      load(4'b1011);
      bit_in(1, 0, 0); bit_in(0, 0, 0); bit_in(1, 0, 0); bit_in(1, 1, 1);
      bit_in(1, 0, 0); bit_in(0, 0, 0); bit_in(1, 0, 0);
      step(1'b0, 4'b1011, 1'b1, 1'b1, 1'b1, 1'b1, 1);
      idle(1);
      chk(K_CNT, 1);
      step(1'b0, 4'b1011, 1'b0, 1'b0, 1'b1, 1'b0, 0);
      chk(K_CNT, 0);
      idle(1);

      // Load collides with the final matching bit
      load(4'b1011);
      bit_in(1, 0, 0); bit_in(0, 0, 0); bit_in(1, 0, 0);
      step(1'b1, 4'b1011, 1'b1, 1'b1, 1'b0, 1'b0, 0);
      idle(1);
      chk(K_CNT, 0);
      bit_in(0, 0, 0); bit_in(1, 0, 0); bit_in(1, 0, 0);
      bit_in(1, 0, 0); bit_in(0, 0, 0); bit_in(1, 0, 0); bit_in(1, 1, 1);
      idle(2);

      // Reset mid-stream
      load(4'b1011);
      bit_in(1, 0, 0); bit_in(0, 0, 0); bit_in(1, 0, 0); bit_in(1, 1, 1);
      bit_in(1, 0, 0); bit_in(0, 0, 0); bit_in(1, 0, 0);
      #2 reset = 1'b0;
      chk(K_ARMED, 0);
      chk(K_CNT, 0);
      @(posedge clk);
      #1;
      reset = 1'b1;
      bit_in(1, 0, 0);
      chk(K_ARMED, 0);
      load(4'b1011);
      bit_in(1, 0, 0);
      idle(1);
      bit_in(0, 0, 0); bit_in(1, 0, 0); bit_in(1, 1, 1);
      idle(2);

      // Six overlapping matches of 1111 for counter limits
      overlap = 1'b1;
      load(4'b1111);
      for (int i = 1; i <= 9; i++) bit_in(1, (i >= 4), i - 3);
      idle(1);
      chk(K_CNT, 6);
      chk(K_CNT2, CNT2_EXP);
      idle(2);

      chk(K_QEMPTY, 0);
      idle(2);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
